// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// Stall bit indices, stall levels, exception offset and FSM encoding.
package pipe_ctrl_pkg;

  localparam int NSTAGE_DEF = 6;
  localparam logic [31:0] EXC_OFFS_DEF = 32'h180;
  localparam int CNT_W_DEF = 32;

  // bit k holds the register after stage k; bit 0 is the pc
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam logic Stop   = 1'b1;
  localparam logic Nostop = 1'b0;

  typedef enum logic {
    RUN      = 1'b0,
    EXC_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall/flush control bundle between pipeline stages and pipe_ctrl.
// master drives requests/exceptions, slave returns stall/flush/redirect.
interface pipe_ctrl_if #(
  parameter int NSTAGE = 6,
  parameter int CNT_W  = 32
);
  logic              stallreq_if_i;
  logic              stallreq_id_i;
  logic              stallreq_ex_i;
  logic              stallreq_mem_i;
  logic              stallreq_align_i;
  logic              excp_i;
  logic              eret_i;
  logic [31:0]       epc_i;
  logic [31:0]       ebase_i;
  logic [NSTAGE-1:0] stall_o;
  logic              flush_o;
  logic [31:0]       new_pc_o;
  logic              exc_wait_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i,
    output stallreq_mem_i, stallreq_align_i,
    output excp_i, eret_i, epc_i, ebase_i,
    input  stall_o, flush_o, new_pc_o, exc_wait_o, stall_cnt_o
  );

  modport slave (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i,
    input  stallreq_mem_i, stallreq_align_i,
    input  excp_i, eret_i, epc_i, ebase_i,
    output stall_o, flush_o, new_pc_o, exc_wait_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl_stall_encoder.sv
// Maps the per-stage request vector to a thermometer stall vector:
// the deepest request stalls itself and every register before it.
module pipe_ctrl_stall_encoder
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE = NSTAGE_DEF
) (
  input  logic [NSTAGE-1:0] req,
  output logic [NSTAGE-1:0] stall
);

  logic acc;

  always_comb begin
    acc   = Nostop;
    stall = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      acc      = acc | req[i];
      stall[i] = acc;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer: merges stall requests, sequences
// exception/ERET flushes and defers them behind a busy mem access.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          NSTAGE   = NSTAGE_DEF,
  parameter logic [31:0] EXC_OFFS = EXC_OFFS_DEF,
  parameter int          CNT_W    = CNT_W_DEF
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);

  state_t            state_q, state_d;
  logic [31:0]       tgt_q, tgt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NSTAGE-1:0] req;
  logic [NSTAGE-1:0] enc_stall;
  logic [NSTAGE-1:0] stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic              exc_wait;
  logic [31:0]       target;
  logic              redirect;

  always_comb begin
    req          = '0;
    req[STG_IF]  = bus.stallreq_if_i;
    req[STG_ID]  = bus.stallreq_id_i;
    req[STG_EX]  = bus.stallreq_ex_i;
    req[STG_MEM] = bus.stallreq_mem_i;
    req[STG_WB]  = bus.stallreq_align_i;
  end

  pipe_ctrl_stall_encoder #(
    .NSTAGE(NSTAGE)
  ) u_enc (
    .req  (req),
    .stall(enc_stall)
  );

  assign redirect = bus.excp_i | bus.eret_i;
  assign target   = (bus.eret_i & ~bus.excp_i)
                  ? bus.epc_i
                  : bus.ebase_i + EXC_OFFS;

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    stall    = '0;
    flush    = 1'b0;
    new_pc   = '0;
    exc_wait = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (redirect && bus.stallreq_mem_i) begin
            // flush is already pending from the deferral cycle on
            stall    = '1;
            exc_wait = 1'b1;
            tgt_d    = target;
            state_d  = EXC_WAIT;
          end else if (redirect) begin
            flush  = 1'b1;
            new_pc = target;
          end else begin
            stall = enc_stall;
          end
        end
        EXC_WAIT: begin
          if (bus.stallreq_mem_i) begin
            stall    = '1;
            exc_wait = 1'b1;
          end else begin
            flush   = 1'b1;
            new_pc  = tgt_q;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (|stall && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.flush_o     = flush;
  assign bus.new_pc_o    = new_pc;
  assign bus.exc_wait_o  = exc_wait;
  assign bus.stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table for the RUN-state
// mapping plus hand sequences for deferred flush, reset and saturation.
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [31:0] cnt_exp;

  pipe_ctrl_if #(.NSTAGE(6), .CNT_W(32)) b1 ();
  pipe_ctrl_if #(.NSTAGE(6), .CNT_W(3))  b2 ();

  pipe_ctrl #(.NSTAGE(6), .EXC_OFFS(32'h180), .CNT_W(32)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(b1.slave)
  );

  pipe_ctrl #(.NSTAGE(6), .EXC_OFFS(32'h180), .CNT_W(3)) u_sat (
    .clk(clk),
    .rst(rst),
    .bus(b2.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0]  req;
    logic        excp;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] ebase;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
  } vec_t;

  vec_t vt[12];

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // req order: {align, mem, ex, id, if}
  task automatic drive(input logic [4:0] r, input logic x,
                       input logic e, input logic [31:0] epc,
                       input logic [31:0] eb);
    b1.stallreq_if_i    = r[0];
    b1.stallreq_id_i    = r[1];
    b1.stallreq_ex_i    = r[2];
    b1.stallreq_mem_i   = r[3];
    b1.stallreq_align_i = r[4];
    b1.excp_i           = x;
    b1.eret_i           = e;
    b1.epc_i            = epc;
    b1.ebase_i          = eb;
  endtask

  task automatic chk(input string nm, input logic [5:0] s,
                     input logic f, input logic [31:0] pc,
                     input logic ew);
    @(negedge clk);
    cmp({nm, ".stall"}, {26'd0, b1.stall_o}, {26'd0, s});
    cmp({nm, ".flush"}, {31'd0, b1.flush_o}, {31'd0, f});
    cmp({nm, ".new_pc"}, b1.new_pc_o, pc);
    cmp({nm, ".exc_wait"}, {31'd0, b1.exc_wait_o}, {31'd0, ew});
    cmp({nm, ".cnt"}, b1.stall_cnt_o, cnt_exp);
    @(posedge clk);
    if (rst) cnt_exp = 0;
    else if (s != 6'd0) cnt_exp = cnt_exp + 1;
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    cnt_exp = 0;
    rst     = 1'b1;
    b2.stallreq_if_i    = 1'b0;
    b2.stallreq_id_i    = 1'b1;
    b2.stallreq_ex_i    = 1'b0;
    b2.stallreq_mem_i   = 1'b0;
    b2.stallreq_align_i = 1'b0;
    b2.excp_i           = 1'b0;
    b2.eret_i           = 1'b0;
    b2.epc_i            = 32'h0;
    b2.ebase_i          = 32'h0;

    vt[0]  = '{5'b00000, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0};
    vt[1]  = '{5'b00001, 0, 0, 32'h0, 32'h0, 6'b000011, 0, 32'h0};
    vt[2]  = '{5'b00010, 0, 0, 32'h0, 32'h0, 6'b000111, 0, 32'h0};
    vt[3]  = '{5'b01010, 0, 0, 32'h0, 32'h0, 6'b011111, 0, 32'h0};
    vt[4]  = '{5'b11010, 0, 0, 32'h0, 32'h0, 6'b111111, 0, 32'h0};
    vt[5]  = '{5'b00110, 0, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0};
    vt[6]  = '{5'b10001, 0, 0, 32'h0, 32'h0, 6'b111111, 0, 32'h0};
    vt[7]  = '{5'b00000, 1, 0, 32'h0, 32'h8000_0000,
               6'b000000, 1, 32'h8000_0180};
    vt[8]  = '{5'b00000, 0, 1, 32'hBFC0_0100, 32'h8000_0000,
               6'b000000, 1, 32'hBFC0_0100};
    vt[9]  = '{5'b00000, 1, 1, 32'hBFC0_0100, 32'h0000_1000,
               6'b000000, 1, 32'h0000_1180};
    vt[10] = '{5'b10110, 1, 0, 32'h0, 32'h8000_0000,
               6'b000000, 1, 32'h8000_0180};
    vt[11] = '{5'b00000, 1, 0, 32'h0, 32'hFFFF_FF00,
               6'b000000, 1, 32'h0000_0080};

    // reset with toggling requests
    drive(5'b11111, 1'b1, 1'b0, 32'h0, 32'h1234_0000);
    chk("rst0", 6'd0, 1'b0, 32'h0, 1'b0);
    drive(5'b01010, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0);
    chk("rst1", 6'd0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    drive(5'b00000, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("idle", 6'd0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].req, vt[i].excp, vt[i].eret, vt[i].epc, vt[i].ebase);
      chk($sformatf("vec%0d", i), vt[i].stall, vt[i].flush,
          vt[i].pc, 1'b0);
    end

    // deferred flush, second exception inside the window ignored
    drive(5'b01000, 1'b1, 1'b0, 32'h0, 32'h2000_0000);
    chk("defer0", 6'h3F, 1'b0, 32'h0, 1'b1);
    drive(5'b01000, 1'b1, 1'b0, 32'h0, 32'h4000_0000);
    chk("defer1", 6'h3F, 1'b0, 32'h0, 1'b1);
    drive(5'b01000, 1'b0, 1'b1, 32'h5555_0000, 32'h0);
    chk("defer2", 6'h3F, 1'b0, 32'h0, 1'b1);
    drive(5'b00000, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("defer_flush", 6'd0, 1'b1, 32'h2000_0180, 1'b0);
    chk("defer_after", 6'd0, 1'b0, 32'h0, 1'b0);

    // deferred ERET keeps epc
    drive(5'b01001, 1'b0, 1'b1, 32'hBFC0_0100, 32'h0);
    chk("deret0", 6'h3F, 1'b0, 32'h0, 1'b1);
    drive(5'b00000, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("deret_flush", 6'd0, 1'b1, 32'hBFC0_0100, 1'b0);

    // reset in the middle of EXC_WAIT
    drive(5'b01000, 1'b1, 1'b0, 32'h0, 32'h3000_0000);
    chk("rw0", 6'h3F, 1'b0, 32'h0, 1'b1);
    chk("rw1", 6'h3F, 1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    drive(5'b00000, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rw_rst", 6'd0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    chk("rw_run", 6'd0, 1'b0, 32'h0, 1'b0);
    drive(5'b00010, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rw_stall", 6'b000111, 1'b0, 32'h0, 1'b0);

    // saturating counter on the narrow instance
    for (int i = 0; i < 9; i++) begin
      drive(5'b00000, 1'b0, 1'b0, 32'h0, 32'h0);
      chk($sformatf("pad%0d", i), 6'd0, 1'b0, 32'h0, 1'b0);
    end
    @(negedge clk);
    cmp("sat_stall", {26'd0, b2.stall_o}, 32'h0000_0007);
    cmp("sat0", {29'd0, b2.stall_cnt_o}, 32'd7);
    @(negedge clk);
    cmp("sat1", {29'd0, b2.stall_cnt_o}, 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
